// File: rtl/dmem_req_ctrl_pkg.sv
// Shared definitions for the data-memory request path: FSM states,
// request/response bundles and the default wait timeout.
package dmem_req_ctrl_pkg;

    localparam int unsigned dmem_timeout_gp = 255;

    typedef enum logic [1:0] {
        DMEM_IDLE      = 2'd0,
        DMEM_REQ_SENT  = 2'd1,
        DMEM_REQ_ACKED = 2'd2
    } dmem_req_state;

    // Core-side request toward data memory
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic [31:0] write_data;
        logic        yumi;           // core accepts read data
    } mem_in_s;

    // Data-memory response toward the core
    typedef struct packed {
        logic        valid;          // read data available
        logic        yumi;           // memory accepted the request
        logic [31:0] read_data;
    } mem_out_s;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store bytes into all lanes and extracts a
// zero-extended little-endian byte from load data.
module dmem_lane_align (
    input  logic        isByte,
    input  logic [1:0]  laneSel,
    input  logic [31:0] storeIn,
    output logic [31:0] storeOut,
    input  logic [31:0] loadIn,
    output logic [31:0] loadOut
);

    logic [7:0] laneByte;

    // Pick the addressed byte lane (lane 0 = bits 7:0)
    always_comb begin
        case (laneSel)
            2'd0:    laneByte = loadIn[7:0];
            2'd1:    laneByte = loadIn[15:8];
            2'd2:    laneByte = loadIn[23:16];
            default: laneByte = loadIn[31:24];
        endcase
    end

    // Byte ops replicate/zero-extend, word ops pass through
    always_comb begin
        storeOut = isByte ? {4{storeIn[7:0]}} : storeIn;
        loadOut  = isByte ? {24'd0, laneByte} : loadIn;
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: issues one LW/LBU/SW/SB at a time,
// handles the two-phase (request ack, then read data) handshake, and
// aborts with a sticky error on misaligned words or wait timeout.
module dmem_req_ctrl
    import dmem_req_ctrl_pkg::*;
#(
    parameter int unsigned timeout_p    = dmem_timeout_gp,
    parameter int unsigned addr_width_p = 32
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    req_valid_i,
    input  logic                    req_wen_i,
    input  logic                    req_byte_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [31:0]             rdata_o,
    output logic                    err_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output mem_in_s                 to_mem_o,
    input  mem_out_s                from_mem_i
);

    dmem_req_state     state;
    logic [31:0]       wdataQ;
    logic              wenQ;
    logic              byteQ;
    logic [7:0]        waitCnt;
    logic [31:0]       storeData;
    logic [31:0]       loadData;
    logic              timeoutHit;
    logic              misaligned;

    dmem_lane_align uAlign (
        .isByte   (byteQ),
        .laneSel  (mem_addr_o[1:0]),
        .storeIn  (wdataQ),
        .storeOut (storeData),
        .loadIn   (from_mem_i.read_data),
        .loadOut  (loadData)
    );

    // Abort condition and word-alignment check on the incoming request
    always_comb begin
        timeoutHit = (waitCnt == 8'(timeout_p));
        misaligned = !req_byte_i && (req_addr_i[1:0] != 2'b00);
        busy_o     = (state != DMEM_IDLE);
    end

    // Memory-side bundle; only live while a request is outstanding so reset
    // drops valid/yumi immediately through the state register
    always_comb begin
        to_mem_o = '0;
        if (state == DMEM_REQ_SENT) begin
            to_mem_o.valid         = 1'b1;
            to_mem_o.wen           = wenQ;
            to_mem_o.byte_not_word = byteQ;
            to_mem_o.write_data    = storeData;
        end
        to_mem_o.yumi = ((state == DMEM_REQ_ACKED) && from_mem_i.valid) ||
                        ((state == DMEM_REQ_SENT) && !wenQ &&
                         from_mem_i.yumi && from_mem_i.valid);
    end

    // Request FSM, wait counter and registered outputs; a memory response
    // in the same cycle as the timeout wins over the abort
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= DMEM_IDLE;
            mem_addr_o <= '0;
            wdataQ     <= '0;
            wenQ       <= 1'b0;
            byteQ      <= 1'b0;
            waitCnt    <= '0;
            rdata_o    <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (req_valid_i) begin
                        if (misaligned) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_addr_o <= req_addr_i;
                            wdataQ     <= req_wdata_i;
                            wenQ       <= req_wen_i;
                            byteQ      <= req_byte_i;
                            waitCnt    <= '0;
                            state      <= DMEM_REQ_SENT;
                        end
                    end
                end
                DMEM_REQ_SENT: begin
                    if (from_mem_i.yumi) begin
                        waitCnt <= '0;
                        if (wenQ) begin
                            state  <= DMEM_IDLE;
                            done_o <= 1'b1;
                        end else if (from_mem_i.valid) begin
                            rdata_o <= loadData;
                            state   <= DMEM_IDLE;
                            done_o  <= 1'b1;
                        end else begin
                            state <= DMEM_REQ_ACKED;
                        end
                    end else if (timeoutHit) begin
                        err_o   <= 1'b1;
                        waitCnt <= '0;
                        state   <= DMEM_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                DMEM_REQ_ACKED: begin
                    if (from_mem_i.valid) begin
                        rdata_o <= loadData;
                        waitCnt <= '0;
                        state   <= DMEM_IDLE;
                        done_o  <= 1'b1;
                    end else if (timeoutHit) begin
                        err_o   <= 1'b1;
                        waitCnt <= '0;
                        state   <= DMEM_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    waitCnt <= '0;
                    state   <= DMEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 SHALL have parameter timeout_p, default 255: max cycles spent waiting in one non-IDLE state before abort, range 1..255.
REQ-002 SHALL have parameter addr_width_p, default 32: width of the request and memory address.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port n_reset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 1: core presents a LW/LBU/SW/SB operation.
REQ-006 SHALL have port req_wen_i, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_byte_i, input, 1: 1 = byte op (LBU/SB), 0 = word op (LW/SW).
REQ-008 SHALL have port req_addr_i, input, addr_width_p: byte address.
REQ-009 SHALL have port req_wdata_i, input, 32: store data.
REQ-010 SHALL have port busy_o, output, 1: high whenever state is not DMEM_IDLE; the core stalls on it.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse when an operation completes.
REQ-012 SHALL have port rdata_o, output, 32: result of the last completed load.
REQ-013 SHALL have port err_o, output, 1: sticky error flag.
REQ-014 SHALL have port mem_addr_o, output, addr_width_p: latched request address.
REQ-015 SHALL have port to_mem_o, output, mem_in_s: request bundle to data memory.
REQ-016 SHALL have port from_mem_i, input, mem_out_s: response bundle from data memory.

Function
REQ-017 SHALL implement an FSM over dmem_req_state with states DMEM_IDLE, DMEM_REQ_SENT and DMEM_REQ_ACKED.
REQ-018 DMEM_IDLE + req_valid_i: latch addr, wdata, wen and byte, then go to DMEM_REQ_SENT on the next edge; req_valid_i in any other state SHALL be ignored.
REQ-019 A word request with req_addr_i[1:0] != 0 SHALL NOT be issued; instead set err_o, stay in DMEM_IDLE and do not pulse done_o.
REQ-020 In DMEM_REQ_SENT, to_mem_o.valid SHALL be 1, and wen and byte_not_word SHALL equal the latched values; otherwise to_mem_o.valid SHALL be 0.
REQ-021 Store data: word gives write_data = latched wdata; byte gives write_data = latched wdata[7:0] replicated into all 4 lanes.
REQ-022 DMEM_REQ_SENT with from_mem_i.yumi=1: a store goes to DMEM_IDLE with done_o pulsed; a load goes to DMEM_REQ_ACKED.
REQ-023 If from_mem_i.yumi and from_mem_i.valid are both 1 on a load in DMEM_REQ_SENT, the load SHALL complete directly: data captured, go to DMEM_IDLE.
REQ-024 When read data is accepted, to_mem_o.yumi SHALL be 1 combinationally, only in the cycle from_mem_i.valid=1 in DMEM_REQ_ACKED or under the REQ-023 case.
REQ-025 Load data: word gives rdata_o = read_data; byte gives rdata_o = zero-extended byte, lane selected by addr[1:0] little-endian (0 selects bits 7:0, 3 selects bits 31:24).
REQ-026 rdata_o SHALL be registered, SHALL update only on load completion, and SHALL be held otherwise.
REQ-027 done_o SHALL be registered and high for exactly the first cycle back in DMEM_IDLE; a new req_valid_i in that same cycle SHALL be accepted.
REQ-028 An 8-bit wait counter SHALL clear on every state change and increment each cycle in DMEM_REQ_SENT or DMEM_REQ_ACKED.
REQ-029 When the wait counter equals timeout_p: set err_o, go to DMEM_IDLE, and do not pulse done_o.
REQ-030 err_o SHALL clear only on reset.

Reset
REQ-031 On n_reset low, asynchronously: state=DMEM_IDLE, all latched fields=0, wait counter=0, rdata_o=0, done_o=0, err_o=0, busy_o=0, to_mem_o all-zero.
REQ-032 Reset asserted mid-operation SHALL abandon the transaction; valid and yumi SHALL drop immediately.

Structure
REQ-033 dmem_req_state, mem_in_s and mem_out_s SHALL come from the shared definitions package; a dmem_timeout_gp=255 constant SHALL be added there as the timeout_p default.
REQ-034 Lane replicate/extract logic SHALL be a combinational sub-module dmem_lane_align; the FSM, counter and registers SHALL stay in dmem_req_ctrl.

Verification
REQ-035 SW to addr 0x40 with data 0xDEADBEEF, yumi 2 cycles after valid: write_data=0xDEADBEEF, wen=1, valid high 2 cycles, done_o pulses once, busy_o then low.
REQ-036 LBU to addr 0x43, memory returns 0x11223344 with yumi then valid 3 cycles later: rdata_o=0x00000011, to_mem_o.yumi high for exactly 1 cycle.
REQ-037 SB of 0x000000A5: write_data=0xA5A5A5A5, byte_not_word=1; LW at 0x80 with yumi and valid in the same cycle gives completion in that cycle's next edge.
REQ-038 LW to addr 0x82: no valid issued, err_o=1, done_o stays 0, and a following aligned LW completes normally with err_o still 1.
REQ-039 LW never acknowledged with timeout_p=4: err_o rises after 4 wait cycles, state returns to DMEM_IDLE, valid drops.
REQ-040 n_reset pulsed low in DMEM_REQ_ACKED: all outputs are zero immediately, and the next request proceeds normally.
